uart_receiver: RTL and testbench
================================

# uart_receiver

8N1 UART receiver. It is the receive-side counterpart to the rover's UART transmitter: same `CLKFREQ`/`BAUDRATE` parameterisation, same system clock. It turns the host-facing serial RX line into validated bytes with a one-cycle strobe, and feeds the CPU comms path. Start bits are validated at mid-bit, stop bits are checked for framing errors, and a byte not consumed before the next one arrives is flagged as an overrun.

## Interface
- `CLKFREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUDRATE`, default 115200: line rate in bit/s. `BIT_TICKS = CLKFREQ/BAUDRATE` (integer division, 868 at defaults). `HALF_TICKS = BIT_TICKS/2` (434).

Ports:
- `sclk`  in  1: system clock. Single clock domain.
- `rstn`  in  1: reset. Asynchronous, active-low.
- `uartRx`  in  1: asynchronous serial input, idle high.
- `rxData`  out  8: last received byte, LSB first on the wire. Held until the next good byte.
- `rxValid`  out  1: one-cycle strobe; `rxData` is new.
- `rxAck`  in  1: consumer has taken `rxData`. May be asserted in the same cycle as `rxValid`.
- `frameErr`  out  1: one-cycle strobe; stop bit sampled low.
- `overrun`  out  1: sticky. Set when a byte is delivered while the previous one is unacked. Cleared by `rxAck`.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- Input passes through a 2-flop synchronizer, reset value 1. All logic uses the synchronized signal `rxS`.
- A bit counter (width `$clog2(BIT_TICKS)`) and a bit index (3 bits) drive the FSM below.
- IDLE: a falling edge on `rxS` (previous 1, current 0) clears the counter and moves to START.
- START: when the counter reaches `HALF_TICKS-1`, sample `rxS`.
  - Sample 0: clear the counter, clear the bit index, go to DATA.
  - Sample 1: false start (glitch). Return to IDLE with no outputs.
- DATA: at each counter value `BIT_TICKS-1`, sample `rxS` into shift-register bit [index], then increment the index and clear the counter. After index 7, go to STOP.
- STOP: at counter value `BIT_TICKS-1`, sample `rxS`.
  - Sample 1: load `rxData` from the shift register, pulse `rxValid`, go to IDLE.
  - Sample 0: pulse `frameErr`, leave `rxData` unchanged, go to BREAK.
- BREAK: wait for `rxS == 1`, then go to IDLE. This prevents a line held low (break condition) from being re-detected as a start bit.
- Overrun handshake:
  - An internal `pending` flag is set by `rxValid` and cleared by `rxAck`.
  - `rxValid` while `pending` is still set (and `rxAck` is not asserted in the same cycle) sets `overrun` and overwrites `rxData`.
  - `rxAck` and `rxValid` in the same cycle: the ack applies to the old byte, `pending` stays set for the new byte, and `overrun` is not set.
- Framing errors never set `pending` or `overrun`.

## Timing
- Reset values: `rxData` = 0x00, `rxValid` = 0, `frameErr` = 0, `overrun` = 0, `busy` = 0. FSM = IDLE, counter = 0, `rxS` = 1.
- Reset asserted mid-frame aborts the frame immediately. No strobe is produced, and the next full frame after release is received correctly.
- Detection latency: 2 cycles (synchronizer) plus 1 cycle (edge detect) after the pin falls.
- Sampling points, relative to the edge-detect cycle:
  - Start bit: `HALF_TICKS` cycles.
  - Data bit n (0..7): `HALF_TICKS + (n+1)*BIT_TICKS` cycles.
  - Stop bit: `HALF_TICKS + 9*BIT_TICKS` cycles.
- `rxValid`/`frameErr` are registered and assert 1 cycle after the stop sample. `rxData` is valid in that same cycle.
- `busy` rises the cycle after edge detection and falls in the `rxValid`/`frameErr` cycle (or on a false start). For the BREAK path, `busy` stays high until the line returns high.
- Back-to-back frames: the next start edge is accepted the cycle after the return to IDLE, which is half a bit before the nominal stop end. Up to ~+/-4% baud mismatch is tolerated.

## Structure
- In `roversPackage`:
  - `typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} uartRxState_t`.
  - Shared `UART_DATA_BITS = 8`.
- Sub-module `bitSync`: parameterised N-flop synchronizer with a reset value parameter. It is reusable for other asynchronous inputs such as ADC lines.
- The main module holds the FSM, counter, shift register and handshake. Expected size is about 150 lines of RTL.

## Test plan
- Send 0xA5 at 115200 baud (8680 ns per bit), with `rxAck` held high → exactly one `rxValid`, `rxData` = 0xA5, `frameErr` = 0, `overrun` = 0.
- Send back-to-back 0x00, 0xFF, 0x55 with a 1-stop-bit gap → three `rxValid` strobes with the correct bytes. Then repeat with baud +3% and −3% and require the same result.
- Drive a 2 µs low glitch on an idle line → no strobes. `busy` pulses high for about 434 cycles, then the FSM is back in IDLE.
- Send 0x3C with the stop bit low, and hold the line low for 20 bit times → one `frameErr` pulse, `rxData` unchanged, no `rxValid`. After the line goes high, a following 0x81 is received correctly.
- Send 0x11 then 0x22 with `rxAck` held low → `overrun` = 1 and `rxData` = 0x22. A single `rxAck` clears `overrun`.
- Pull `rstn` low during data bit 4 of a frame, then release → all outputs read their reset values. The remainder of the aborted frame produces no strobe, and the next full frame 0xC3 is received.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared rover definitions: UART receiver state encoding and frame width.
`timescale 1ns/1ps
package roversPackage;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uartRxState_t;

endpackage

// File: rtl/uart_receiver_bit_sync.sv
// N-flop synchronizer for a single asynchronous input with a selectable reset
// value, so idle-high lines (UART RX) and idle-low lines alike come out of
// reset in their quiet state. STAGES must be at least 2.
`timescale 1ns/1ps
module bitSync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] syncReg;

  // Shift the raw input through the flop chain; the last stage is the clean copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      syncReg <= {STAGES{RESET_VALUE}};
    end else begin
      syncReg <= {syncReg[STAGES-2:0], d};
    end
  end

  assign q = syncReg[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, framing-error detection with break
// hold-off, and a pending/overrun handshake toward the consumer.
`timescale 1ns/1ps
module uart_receiver
  import roversPackage::*;
#(
  parameter int CLKFREQ  = 100_000_000,
  parameter int BAUDRATE = 115200
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       uartRx,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxAck,
  output logic       frameErr,
  output logic       overrun,
  output logic       busy
);

  localparam int BIT_TICKS  = CLKFREQ / BAUDRATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = $clog2(BIT_TICKS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic                      rxS;
  logic                      rxPrev;
  uartRxState_t              state;
  logic [CNT_W-1:0]          bitCnt;
  logic [2:0]                bitIdx;
  logic [UART_DATA_BITS-1:0] shiftReg;
  logic                      pending;

  bitSync #(
    .STAGES     (2),
    .RESET_VALUE(1'b1)
  ) rxSync (
    .clk (sclk),
    .rstn(rstn),
    .d   (uartRx),
    .q   (rxS)
  );

  // Remember the previous synchronized level so IDLE can spot a falling edge.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      rxPrev <= 1'b1;
    end else begin
      rxPrev <= rxS;
    end
  end

  // Frame FSM: validate start at mid-bit, shift in data, check stop, wait out breaks.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state    <= RX_IDLE;
      bitCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rxPrev && !rxS) begin
            bitCnt <= '0;
            state  <= RX_START;
          end
        end
        RX_START: begin
          if (bitCnt == HALF_LAST) begin
            if (!rxS) begin
              bitCnt <= '0;
              bitIdx <= '0;
              state  <= RX_DATA;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (bitCnt == BIT_LAST) begin
            shiftReg[bitIdx] <= rxS;
            bitIdx           <= bitIdx + 3'd1;
            bitCnt           <= '0;
            if (bitIdx == IDX_LAST) begin
              state <= RX_STOP;
            end
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (bitCnt == BIT_LAST) begin
            bitCnt <= '0;
            if (rxS) begin
              rxData  <= shiftReg;
              rxValid <= 1'b1;
              state   <= RX_IDLE;
            end else begin
              frameErr <= 1'b1;
              state    <= RX_BREAK;
            end
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end
        RX_BREAK: begin
          if (rxS) begin
            state <= RX_IDLE;
          end
        end
        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end

  // Track whether the delivered byte is still unconsumed; a same-cycle ack belongs to the old byte.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (rxValid) begin
        pending <= 1'b1;
      end else if (rxAck) begin
        pending <= 1'b0;
      end
      if (rxValid && pending && !rxAck) begin
        overrun <= 1'b1;
      end else if (rxAck) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver. The receiver runs at 64 clocks per bit so
// frames stay short; all expected timing is expressed in bit ticks.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int  TB_CLKFREQ = 6_400_000;
  localparam int  TB_BAUD    = 100_000;
  localparam int  BIT_TICKS  = TB_CLKFREQ / TB_BAUD;
  localparam int  HALF_TICKS = BIT_TICKS / 2;
  localparam real CLK_NS     = 10.0;
  localparam real BIT_NS     = BIT_TICKS * CLK_NS;

  logic       sclk;
  logic       rstn;
  logic       uartRx;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxAck;
  logic       frameErr;
  logic       overrun;
  logic       busy;

  int checkCount = 0;
  int errorCount = 0;

  int         cycleCnt = 0;
  int         startCycle = 0;
  int         lastValidCycle = 0;
  int         ferrCount = 0;
  int         busyCycles = 0;
  logic [7:0] rxLog[$];

  uart_receiver #(
    .CLKFREQ (TB_CLKFREQ),
    .BAUDRATE(TB_BAUD)
  ) dut (
    .sclk    (sclk),
    .rstn    (rstn),
    .uartRx  (uartRx),
    .rxData  (rxData),
    .rxValid (rxValid),
    .rxAck   (rxAck),
    .frameErr(frameErr),
    .overrun (overrun),
    .busy    (busy)
  );

  // Free-running clock, 10 ns period.
  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // Cycle counter advanced on every active edge.
  always @(posedge sclk) cycleCnt <= cycleCnt + 1;

  // Log delivered bytes and count strobe/busy cycles on the inactive edge.
  always @(negedge sclk) begin
    if (rxValid) begin
      rxLog.push_back(rxData);
      lastValidCycle <= cycleCnt;
    end
    if (frameErr) ferrCount <= ferrCount + 1;
    if (busy) busyCycles <= busyCycles + 1;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one 8N1 frame LSB first; the line is left at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input real bitNs);
    uartRx     = 1'b0;
    startCycle = cycleCnt;
    #(bitNs);
    for (int i = 0; i < 8; i++) begin
      uartRx = data[i];
      #(bitNs);
    end
    uartRx = stopBit;
    #(bitNs);
  endtask

  // Assert rxAck exactly in the cycle rxValid is high.
  task automatic ackOnValid();
    int n;
    n = 0;
    do begin
      @(negedge sclk);
      n++;
    end while (!rxValid && n < 2000);
    checkOutput("ackWaitValid", 32'(rxValid), 32'd1);
    rxAck = 1'b1;
    @(negedge sclk);
    rxAck = 1'b0;
  endtask

  function automatic logic [31:0] byteAt(input int idx);
    if (idx < rxLog.size()) return 32'(rxLog[idx]);
    return 32'hDEAD;
  endfunction

  task automatic idleBits(input int n);
    repeat (n * BIT_TICKS) @(negedge sclk);
  endtask

  real        speedFactor[3] = '{1.00, 1.03, 0.97};
  logic [7:0] burst[3]       = '{8'h00, 8'hFF, 8'h55};

  initial begin
    int base;
    int ferrBase;
    int busyBase;
    rstn   = 1'b0;
    uartRx = 1'b1;
    rxAck  = 1'b1;
    repeat (3) @(negedge sclk);
    checkOutput("resetRxData", 32'(rxData), 32'h00);
    checkOutput("resetRxValid", 32'(rxValid), 32'd0);
    checkOutput("resetFrameErr", 32'(frameErr), 32'd0);
    checkOutput("resetOverrun", 32'(overrun), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge sclk);

    // Single byte with ack held high; also pins down the stop-sample latency.
    @(negedge sclk);
    applyStimulus(8'hA5, 1'b1, BIT_NS);
    idleBits(2);
    checkOutput("a5Count", 32'(rxLog.size()), 32'd1);
    checkOutput("a5Data", byteAt(0), 32'hA5);
    checkOutput("a5RxData", 32'(rxData), 32'hA5);
    checkOutput("a5FrameErr", 32'(ferrCount), 32'd0);
    checkOutput("a5Overrun", 32'(overrun), 32'd0);
    checkOutput("a5Latency", 32'(lastValidCycle - startCycle), 32'(3 + HALF_TICKS + 9 * BIT_TICKS));
    checkOutput("a5BusyIdle", 32'(busy), 32'd0);

    // Back-to-back burst at nominal, +3% and -3% baud.
    for (int s = 0; s < 3; s++) begin
      real bitNs;
      bitNs = BIT_NS / speedFactor[s];
      base  = rxLog.size();
      @(negedge sclk);
      for (int k = 0; k < 3; k++) applyStimulus(burst[k], 1'b1, bitNs);
      idleBits(2);
      checkOutput($sformatf("burst%0dCount", s), 32'(rxLog.size() - base), 32'd3);
      for (int k = 0; k < 3; k++)
        checkOutput($sformatf("burst%0dByte%0d", s, k), byteAt(base + k), 32'(burst[k]));
      checkOutput($sformatf("burst%0dFrameErr", s), 32'(ferrCount), 32'd0);
    end

    // Short low glitch on an idle line: false start, no strobes.
    base     = rxLog.size();
    busyBase = busyCycles;
    @(negedge sclk);
    uartRx = 1'b0;
    #(20 * CLK_NS);
    uartRx = 1'b1;
    repeat (200) @(negedge sclk);
    checkOutput("glitchNoValid", 32'(rxLog.size() - base), 32'd0);
    checkOutput("glitchNoFrameErr", 32'(ferrCount), 32'd0);
    checkOutput("glitchBusyCycles", 32'(busyCycles - busyBase), 32'(HALF_TICKS));
    checkOutput("glitchBusyIdle", 32'(busy), 32'd0);

    // Low stop bit followed by a long break, then a clean byte.
    base     = rxLog.size();
    ferrBase = ferrCount;
    @(negedge sclk);
    applyStimulus(8'h3C, 1'b0, BIT_NS);
    #(10 * BIT_NS);
    checkOutput("breakBusy", 32'(busy), 32'd1);
    #(10 * BIT_NS);
    uartRx = 1'b1;
    idleBits(2);
    checkOutput("breakFrameErr", 32'(ferrCount - ferrBase), 32'd1);
    checkOutput("breakNoValid", 32'(rxLog.size() - base), 32'd0);
    checkOutput("breakRxDataHeld", 32'(rxData), 32'h55);
    checkOutput("breakBusyIdle", 32'(busy), 32'd0);
    @(negedge sclk);
    applyStimulus(8'h81, 1'b1, BIT_NS);
    idleBits(2);
    checkOutput("afterBreakCount", 32'(rxLog.size() - base), 32'd1);
    checkOutput("afterBreakData", 32'(rxData), 32'h81);

    // Overrun: two bytes without an ack, then one ack clears it.
    rxAck = 1'b0;
    @(negedge sclk);
    applyStimulus(8'h11, 1'b1, BIT_NS);
    idleBits(1);
    checkOutput("firstUnackedOverrun", 32'(overrun), 32'd0);
    applyStimulus(8'h22, 1'b1, BIT_NS);
    idleBits(1);
    checkOutput("overrunSet", 32'(overrun), 32'd1);
    checkOutput("overrunData", 32'(rxData), 32'h22);
    @(negedge sclk);
    rxAck = 1'b1;
    @(negedge sclk);
    rxAck = 1'b0;
    repeat (2) @(negedge sclk);
    checkOutput("overrunCleared", 32'(overrun), 32'd0);

    // Ack in the same cycle as a new byte: no overrun, new byte stays pending.
    applyStimulus(8'h44, 1'b1, BIT_NS);
    idleBits(1);
    checkOutput("pendingNoOverrun", 32'(overrun), 32'd0);
    @(negedge sclk);
    fork
      applyStimulus(8'h66, 1'b1, BIT_NS);
      ackOnValid();
    join
    idleBits(1);
    checkOutput("sameCycleAckOverrun", 32'(overrun), 32'd0);
    checkOutput("sameCycleAckData", 32'(rxData), 32'h66);
    applyStimulus(8'h77, 1'b1, BIT_NS);
    idleBits(1);
    checkOutput("stillPendingOverrun", 32'(overrun), 32'd1);

    // Reset during data bit 4 of 0xF0; the tail of the frame is all ones.
    base     = rxLog.size();
    ferrBase = ferrCount;
    @(negedge sclk);
    fork
      applyStimulus(8'hF0, 1'b1, BIT_NS);
      begin
        #(5 * BIT_NS + 200.0);
        rstn = 1'b0;
        #100;
        checkOutput("midResetRxData", 32'(rxData), 32'h00);
        checkOutput("midResetRxValid", 32'(rxValid), 32'd0);
        checkOutput("midResetFrameErr", 32'(frameErr), 32'd0);
        checkOutput("midResetOverrun", 32'(overrun), 32'd0);
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        #100;
        rstn = 1'b1;
      end
    join
    idleBits(2);
    checkOutput("abortedNoValid", 32'(rxLog.size() - base), 32'd0);
    checkOutput("abortedNoFrameErr", 32'(ferrCount - ferrBase), 32'd0);
    @(negedge sclk);
    applyStimulus(8'hC3, 1'b1, BIT_NS);
    idleBits(2);
    checkOutput("postResetCount", 32'(rxLog.size() - base), 32'd1);
    checkOutput("postResetData", 32'(rxData), 32'hC3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
